id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS core; captures decoded operands and control from ID and presents them to EX.
- Its registered rs, rt, write-register and control outputs feed the EX-stage forwarding unit and ALU muxes.
- Integrates load-use hazard detection (bubble insertion plus upstream hold), branch flush, global stall and a WB-to-ID write-through bypass.
- Keeps a saturating load-use bubble counter for performance debug.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/hazard_detect.sv | 38 +++
 rtl/id_ex_stage.sv | 195 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: ALU op encodings and the
// control bundle carried through the ID/EX, EX/MEM and MEM/WB registers.
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

    // An invalid instruction must never carry live control into EX.
    function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic valid);
        ctrl_t r;
        if (valid) begin
            r = c;
        end else begin
            r = CTRL_NOP;
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection between the ID instruction and a
// load sitting in EX, plus the upstream write enables derived from it.
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_write_reg,
    input  logic              flush,
    input  logic              stall_ext,
    output logic              haz,
    output logic              load_use_stall,
    output logic              pc_write,
    output logic              if_id_write
);

    logic rs_match_s;
    logic rt_match_s;
    logic stall_any_s;

    assign rs_match_s = id_use_rs && (id_rs == ex_write_reg);
    assign rt_match_s = id_use_rt && (id_rt == ex_write_reg);

    assign haz = id_valid && ex_valid && ex_mem_read
                 && (ex_write_reg != {REG_AW{1'b0}})
                 && (rs_match_s || rt_match_s);

    assign load_use_stall = haz && !flush && !stall_ext;
    assign stall_any_s    = stall_ext || load_use_stall;
    assign pc_write       = !stall_any_s;
    assign if_id_write    = !stall_any_s;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, global
// stall, WB-to-ID write-through bypass and a saturating bubble counter.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_ext,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic [3:0]        id_alu_op,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic [3:0]        ex_alu_op,
    output logic [REG_AW-1:0] ex_write_reg,
    output logic              load_use_stall,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [REG_AW-1:0] rt_q, rt_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    ctrl_t             ctrl_id_s;
    logic              haz_s;
    logic              bypass_rs_s;
    logic              bypass_rt_s;

    assign ctrl_id_s = '{id_reg_write, id_mem_read, id_mem_write,
                         id_mem_to_reg, id_alu_src, id_reg_dst, id_alu_op};

    // $0 is hardwired, so a WB write aimed at it must never be forwarded.
    assign bypass_rs_s = wb_reg_write && (wb_write_reg != {REG_AW{1'b0}})
                         && (wb_write_reg == id_rs);
    assign bypass_rt_s = wb_reg_write && (wb_write_reg != {REG_AW{1'b0}})
                         && (wb_write_reg == id_rt);

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_use_rs      (id_use_rs),
        .id_use_rt      (id_use_rt),
        .ex_valid       (valid_q),
        .ex_mem_read    (ctrl_q.mem_read),
        .ex_write_reg   (ex_write_reg),
        .flush          (flush),
        .stall_ext      (stall_ext),
        .haz            (haz_s),
        .load_use_stall (load_use_stall),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write)
    );

    // Next-state selection: freeze, then flush, then load-use bubble, then capture.
    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        ctrl_d       = ctrl_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_ext) begin
            valid_d = valid_q;
        end else if (flush || haz_s) begin
            valid_d = 1'b0;
            pc_d    = {DATA_W{1'b0}};
            rd1_d   = {DATA_W{1'b0}};
            rd2_d   = {DATA_W{1'b0}};
            imm_d   = {DATA_W{1'b0}};
            rs_d    = {REG_AW{1'b0}};
            rt_d    = {REG_AW{1'b0}};
            rd_d    = {REG_AW{1'b0}};
            ctrl_d  = CTRL_NOP;
            if (!flush && (bubble_cnt_q != {CNT_W{1'b1}})) begin
                bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                bubble_cnt_d = bubble_cnt_q;
            end
        end else begin
            valid_d = id_valid;
            pc_d    = id_pc;
            imm_d   = id_imm;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            ctrl_d  = ctrl_gate(ctrl_id_s, id_valid);
            if (bypass_rs_s) begin
                rd1_d = wb_write_data;
            end else begin
                rd1_d = id_rd1;
            end
            if (bypass_rt_s) begin
                rd2_d = wb_write_data;
            end else begin
                rd2_d = id_rd2;
            end
        end
    end

    // Pipeline register and bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            pc_q         <= {DATA_W{1'b0}};
            rd1_q        <= {DATA_W{1'b0}};
            rd2_q        <= {DATA_W{1'b0}};
            imm_q        <= {DATA_W{1'b0}};
            rs_q         <= {REG_AW{1'b0}};
            rt_q         <= {REG_AW{1'b0}};
            rd_q         <= {REG_AW{1'b0}};
            ctrl_q       <= CTRL_NOP;
            bubble_cnt_q <= {CNT_W{1'b0}};
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            ctrl_q       <= ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_rd1        = rd1_q;
    assign ex_rd2        = rd2_q;
    assign ex_imm        = imm_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_dst    = ctrl_q.reg_dst;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_write_reg  = ctrl_q.reg_dst ? rd_q : rt_q;
    assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; a second instance with a
// 2-bit counter shares the stimulus to exercise bubble-counter saturation.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_ext, flush, id_valid;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_use_rs, id_use_rt;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
    logic [3:0]  id_alu_op;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;

    logic        ex_valid;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_write_reg;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
    logic [3:0]  ex_alu_op;
    logic        load_use_stall, pc_write, if_id_write;
    logic [15:0] bubble_cnt;

    logic        s_ex_valid;
    logic [31:0] s_ex_pc, s_ex_rd1, s_ex_rd2, s_ex_imm;
    logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd, s_ex_write_reg;
    logic        s_ex_reg_write, s_ex_mem_read, s_ex_mem_write, s_ex_mem_to_reg, s_ex_alu_src, s_ex_reg_dst;
    logic [3:0]  s_ex_alu_op;
    logic        s_load_use_stall, s_pc_write, s_if_id_write;
    logic [1:0]  s_bubble_cnt;

    int n_checks;
    int n_errors;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_ext(stall_ext), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op),
        .ex_write_reg(ex_write_reg), .load_use_stall(load_use_stall), .pc_write(pc_write),
        .if_id_write(if_id_write), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall_ext(stall_ext), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data),
        .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rd1(s_ex_rd1), .ex_rd2(s_ex_rd2), .ex_imm(s_ex_imm),
        .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_reg_write(s_ex_reg_write),
        .ex_mem_read(s_ex_mem_read), .ex_mem_write(s_ex_mem_write), .ex_mem_to_reg(s_ex_mem_to_reg),
        .ex_alu_src(s_ex_alu_src), .ex_reg_dst(s_ex_reg_dst), .ex_alu_op(s_ex_alu_op),
        .ex_write_reg(s_ex_write_reg), .load_use_stall(s_load_use_stall), .pc_write(s_pc_write),
        .if_id_write(s_if_id_write), .bubble_cnt(s_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lw(input logic [4:0] rt, input logic [31:0] pc);
        id_valid = 1'b1; id_pc = pc; id_rs = 5'd1; id_rt = rt; id_rd = 5'd0;
        id_use_rs = 1'b1; id_use_rt = 1'b0;
        id_rd1 = 32'h0000_1000; id_rd2 = 32'h0; id_imm = 32'h0000_0004;
        id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b0;
        id_mem_to_reg = 1'b1; id_alu_src = 1'b1; id_reg_dst = 1'b0; id_alu_op = 4'd2;
    endtask

    task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] pc);
        id_valid = 1'b1; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd;
        id_use_rs = 1'b1; id_use_rt = 1'b1;
        id_rd1 = 32'h0000_AAAA; id_rd2 = 32'h0000_BBBB; id_imm = 32'h0;
        id_reg_write = 1'b1; id_mem_read = 1'b0; id_mem_write = 1'b0;
        id_mem_to_reg = 1'b0; id_alu_src = 1'b0; id_reg_dst = 1'b1; id_alu_op = 4'd2;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; stall_ext = 1'b0; flush = 1'b0;
        set_add(5'd0, 5'd0, 5'd0, 32'h0);
        id_valid = 1'b0;
        wb_reg_write = 1'b0; wb_write_reg = 5'd0; wb_write_data = 32'h0;
        #2;
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
        check("rst_pc", ex_pc, 32'd0);
        #10;
        rst_n = 1'b1;
        #1;

        // lw $8 into EX, then dependent add in ID
        set_lw(5'd8, 32'h104);
        step();
        check("lw_valid", {31'd0, ex_valid}, 32'd1);
        check("lw_memrd", {31'd0, ex_mem_read}, 32'd1);
        check("lw_wreg", {27'd0, ex_write_reg}, 32'd8);
        check("lw_pc", ex_pc, 32'h104);
        set_add(5'd8, 5'd2, 5'd9, 32'h108);
        #1;
        check("lu_stall", {31'd0, load_use_stall}, 32'd1);
        check("lu_pcw", {31'd0, pc_write}, 32'd0);
        check("lu_ifid", {31'd0, if_id_write}, 32'd0);
        step();
        check("bub_valid", {31'd0, ex_valid}, 32'd0);
        check("bub_regw", {31'd0, ex_reg_write}, 32'd0);
        check("bub_memrd", {31'd0, ex_mem_read}, 32'd0);
        check("bub_rs", {27'd0, ex_rs}, 32'd0);
        check("bub_cnt", {16'd0, bubble_cnt}, 32'd1);
        check("bub_nostall", {31'd0, load_use_stall}, 32'd0);
        check("bub_pcw", {31'd0, pc_write}, 32'd1);
        step();
        check("add_valid", {31'd0, ex_valid}, 32'd1);
        check("add_rs", {27'd0, ex_rs}, 32'd8);
        check("add_rd1", ex_rd1, 32'h0000_AAAA);
        check("add_wreg", {27'd0, ex_write_reg}, 32'd9);
        check("add_cnt", {16'd0, bubble_cnt}, 32'd1);

        // load to $0 followed by a reader of $0: no hazard
        set_lw(5'd0, 32'h10C);
        step();
        check("lw0_wreg", {27'd0, ex_write_reg}, 32'd0);
        set_add(5'd0, 5'd0, 5'd3, 32'h110);
        #1;
        check("r0_stall", {31'd0, load_use_stall}, 32'd0);
        check("r0_pcw", {31'd0, pc_write}, 32'd1);
        step();
        check("r0_pc", ex_pc, 32'h110);

        // flush with a concurrent hazard
        set_lw(5'd8, 32'h114);
        step();
        set_add(5'd8, 5'd2, 5'd9, 32'h118);
        flush = 1'b1;
        #1;
        check("fl_stall", {31'd0, load_use_stall}, 32'd0);
        check("fl_pcw", {31'd0, pc_write}, 32'd1);
        step();
        flush = 1'b0;
        check("fl_valid", {31'd0, ex_valid}, 32'd0);
        check("fl_regw", {31'd0, ex_reg_write}, 32'd0);
        check("fl_pc", ex_pc, 32'd0);
        check("fl_cnt", {16'd0, bubble_cnt}, 32'd1);

        // global stall holding a load with a pending hazard behind it
        set_lw(5'd8, 32'h200);
        step();
        set_add(5'd8, 5'd2, 5'd9, 32'h204);
        stall_ext = 1'b1;
        #1;
        check("st_pcw", {31'd0, pc_write}, 32'd0);
        check("st_lus", {31'd0, load_use_stall}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            id_pc = 32'h300 + 32'(i);
            id_rd1 = 32'h5000 + 32'(i);
            step();
            check("st_pc", ex_pc, 32'h200);
            check("st_valid", {31'd0, ex_valid}, 32'd1);
            check("st_memrd", {31'd0, ex_mem_read}, 32'd1);
            check("st_cnt", {16'd0, bubble_cnt}, 32'd1);
        end
        stall_ext = 1'b0;
        set_add(5'd8, 5'd2, 5'd9, 32'h204);
        #1;
        check("rel_lus", {31'd0, load_use_stall}, 32'd1);
        step();
        check("rel_valid", {31'd0, ex_valid}, 32'd0);
        check("rel_cnt", {16'd0, bubble_cnt}, 32'd2);
        step();
        check("rel_pc", ex_pc, 32'h204);

        // WB write-through bypass
        set_add(5'd5, 5'd5, 5'd6, 32'h400);
        id_rd1 = 32'h11; id_rd2 = 32'h11;
        wb_reg_write = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'hDEAD_BEEF;
        step();
        check("byp_rd1", ex_rd1, 32'hDEAD_BEEF);
        check("byp_rd2", ex_rd2, 32'hDEAD_BEEF);
        id_rs = 5'd0; id_rt = 5'd0; wb_write_reg = 5'd0;
        step();
        check("byp0_rd1", ex_rd1, 32'h11);
        check("byp0_rd2", ex_rd2, 32'h11);
        wb_reg_write = 1'b0;

        // invalid instruction with control asserted
        set_lw(5'd7, 32'h500);
        id_mem_write = 1'b1;
        id_valid = 1'b0;
        step();
        check("inv_valid", {31'd0, ex_valid}, 32'd0);
        check("inv_regw", {31'd0, ex_reg_write}, 32'd0);
        check("inv_memw", {31'd0, ex_mem_write}, 32'd0);
        check("inv_memrd", {31'd0, ex_mem_read}, 32'd0);

        // five more bubbles: wide counter 2->7, narrow one saturates at 3
        for (int i = 0; i < 5; i++) begin
            set_lw(5'd8, 32'h600);
            step();
            set_add(5'd8, 5'd2, 5'd9, 32'h604);
            step();
        end
        check("sat_wide", {16'd0, bubble_cnt}, 32'd7);
        check("sat_narrow", {30'd0, s_bubble_cnt}, 32'd3);

        // asynchronous reset mid-cycle
        set_add(5'd3, 5'd4, 5'd5, 32'h700);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, ex_valid}, 32'd0);
        check("arst_pc", ex_pc, 32'd0);
        check("arst_rd1", ex_rd1, 32'd0);
        check("arst_cnt", {16'd0, bubble_cnt}, 32'd0);
        check("arst_scnt", {30'd0, s_bubble_cnt}, 32'd0);
        #3;
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
